// File: rtl/serial_sub_pkg.sv
// Shared constants and types for the bit-serial subtraction controller.
package serial_sub_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

    // Bit-counter width: enough to hold the value WIDTH.
    function automatic int unsigned cw_of(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - cin with borrow-out.
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_d,
    output logic o_bout
);

    assign o_d    = i_a ^ i_b ^ i_cin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_cin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - bin over WIDTH bits, one bit per clock, with start/busy/done handshake.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CW    = cw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff_sh;
    logic             r_brw;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_zero;

    logic             w_d;
    logic             w_b_next;
    logic [WIDTH-1:0] w_diff_next;
    logic             w_last;
    logic             w_accept;

    full_subtractor u_fs (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_brw),
        .o_d    (w_d),
        .o_bout (w_b_next)
    );

    assign w_diff_next = {w_d, r_diff_sh[WIDTH-1:1]};
    assign w_last      = (r_cnt == CW'(WIDTH - 1));
    // The DONE-exit edge also serves as an IDLE sampling edge, giving WIDTH+1 spacing.
    assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_diff_sh <= '0;
            r_brw     <= 1'b0;
            r_cnt     <= '0;
            r_diff    <= '0;
            r_bout    <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_a_sh    <= a;
                        r_b_sh    <= b;
                        r_brw     <= bin;
                        r_cnt     <= '0;
                        r_diff_sh <= '0;
                        r_state   <= S_RUN;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a_sh    <= r_a_sh >> 1;
                    r_b_sh    <= r_b_sh >> 1;
                    r_diff_sh <= w_diff_next;
                    r_brw     <= w_b_next;
                    r_cnt     <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff  <= w_diff_next;
                        r_bout  <= w_b_next;
                        r_zero  <= (w_diff_next == '0);
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign diff = r_diff;
    assign bout = r_bout;
    assign zero = r_zero;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed self-checking bench for serial_sub_ctrl at WIDTH=8.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       bin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic       zero;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from idle; lat is the edge count from accept to done (-1 on timeout).
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                         output int lat, output logic [7:0] od, output logic ob,
                         output logic oz);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1; od = 'x; ob = 1'bx; oz = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done) begin
                lat = k; od = diff; ob = bout; oz = zero;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0 || zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset: busy=%b done=%b diff=%h bout=%b zero=%b, want all 0",
                     busy, done, diff, bout, zero);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int done_at;
        int busy_bad;
        a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        done_at = -1; busy_bad = 0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL basic_busy_E: busy=%b want 1", busy);
        end
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                if (done_at < 0) done_at = k;
                n_checks++;
                if (diff !== 8'h23 || bout !== 1'b0 || zero !== 1'b0) begin
                    n_err++;
                    $display("FAIL basic_result: diff=%h bout=%b zero=%b want 23 0 0",
                             diff, bout, zero);
                end
            end
        end
        n_checks++;
        if (done_at != 8) begin
            n_err++; $display("FAIL basic_latency: done at E+%0d want E+8", done_at);
        end
        n_checks++;
        if (busy_bad != 1) begin
            n_err++; $display("FAIL basic_busy_window: %0d low samples in E+1..E+9, want 1",
                              busy_bad);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h23) begin
            n_err++; $display("FAIL basic_after: busy=%b done=%b diff=%h want 0 0 23",
                              busy, done, diff);
        end
    endtask

    task automatic test_borrow_cases();
        int lat; logic [7:0] d; logic bo; logic z;
        do_op(8'h00, 8'h01, 1'b0, lat, d, bo, z);
        n_checks++;
        if (lat != 8 || d !== 8'hFF || bo !== 1'b1 || z !== 1'b0) begin
            n_err++; $display("FAIL underflow: lat=%0d diff=%h bout=%b zero=%b want 8 ff 1 0",
                              lat, d, bo, z);
        end
        do_op(8'h80, 8'h7F, 1'b1, lat, d, bo, z);
        n_checks++;
        if (lat != 8 || d !== 8'h00 || bo !== 1'b0 || z !== 1'b1) begin
            n_err++; $display("FAIL zero_bin: lat=%0d diff=%h bout=%b zero=%b want 8 00 0 1",
                              lat, d, bo, z);
        end
        do_op(8'hC3, 8'h5A, 1'b1, lat, d, bo, z);
        n_checks++;
        if (lat != 8 || d !== 8'h68 || bo !== 1'b0 || z !== 1'b0) begin
            n_err++; $display("FAIL mixed: lat=%0d diff=%h bout=%b zero=%b want 8 68 0 0",
                              lat, d, bo, z);
        end
    endtask

    task automatic test_start_while_busy();
        int n_done;
        int done_at;
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n_done = 0; done_at = -1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
            end
            tick();
            if (k == 3) start = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = k;
                    n_checks++;
                    if (diff !== 8'h0F || bout !== 1'b0) begin
                        n_err++; $display("FAIL ignore_result: diff=%h bout=%b want 0f 0",
                                          diff, bout);
                    end
                end
            end
        end
        n_checks++;
        if (done_at != 8 || n_done != 1) begin
            n_err++; $display("FAIL ignore_done: first at E+%0d count %0d want E+8 and 1",
                              done_at, n_done);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [7:0] d; logic bo; logic z;
        int n_done;
        a = 8'h44; b = 8'h11; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0 || zero !== 1'b0) begin
            n_err++; $display("FAIL async_reset: busy=%b done=%b diff=%h bout=%b zero=%b want 0",
                              busy, done, diff, bout, zero);
        end
        tick();
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done != 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL abort_no_done: %0d done pulses busy=%b want 0 0", n_done, busy);
        end
        do_op(8'h09, 8'h03, 1'b0, lat, d, bo, z);
        n_checks++;
        if (lat != 8 || d !== 8'h06 || bo !== 1'b0 || z !== 1'b0) begin
            n_err++; $display("FAIL post_reset: lat=%0d diff=%h bout=%b zero=%b want 8 06 0 0",
                              lat, d, bo, z);
        end
    endtask

    task automatic test_back_to_back();
        int pulses[$];
        int unstable;
        int waited;
        logic [7:0] prev;
        a = 8'h05; b = 8'h07; bin = 1'b0; start = 1'b1;
        tick();
        unstable = 0;
        prev = diff;
        for (int k = 1; k <= 29; k++) begin
            tick();
            if (done === 1'b1) begin
                pulses.push_back(k);
                n_checks++;
                if (diff !== 8'hFE || bout !== 1'b1) begin
                    n_err++; $display("FAIL b2b_result at E+%0d: diff=%h bout=%b want fe 1",
                                      k, diff, bout);
                end
            end else if (pulses.size() > 0 && diff !== prev) begin
                unstable++;
            end
            prev = diff;
        end
        start = 1'b0;
        n_checks++;
        if (pulses.size() != 3 || pulses[0] != 8 || pulses[1] != 17 || pulses[2] != 26) begin
            n_err++; $display("FAIL b2b_spacing: %0d pulses first=%0d want 3 at 8,17,26",
                              pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
        end
        n_checks++;
        if (unstable != 0) begin
            n_err++; $display("FAIL b2b_stable: diff changed %0d times between pulses", unstable);
        end
        waited = 0;
        while (busy === 1'b1 && waited < 30) begin
            tick();
            waited++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL b2b_drain: busy=%b after %0d cycles want 0", busy, waited);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_cases();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
